// File: rtl/regfile_write_sequencer.sv
// Register-file write-port arbiter: ALU results take priority, loads queue in an in-order FIFO.
// Define WB_LOAD_BYPASS_EN to let a load skip the FIFO when it is empty and the ALU is idle.
module regfile_write_sequencer #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        aluValid,
  input  logic [REG_ADDR_W-1:0]       aluRd,
  input  logic [XLEN-1:0]             aluData,
  input  logic                        loadValid,
  output logic                        loadReady,
  input  logic [REG_ADDR_W-1:0]       loadRd,
  input  logic [XLEN-1:0]             loadData,
  output logic                        writeEnable,
  output logic [REG_ADDR_W-1:0]       desRegister,
  output logic [XLEN-1:0]             writeData,
  output logic [2**REG_ADDR_W-1:0]    pendingMask,
  output logic [$clog2(DEPTH):0]      fifoCount
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [REG_ADDR_W-1:0] r_rd   [DEPTH];
  logic [XLEN-1:0]       r_data [DEPTH];
  logic [DEPTH-1:0]      r_live;
  logic [PTR_W-1:0]      r_head, r_tail;
  logic [PTR_W:0]        r_count;

  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_des;
  logic [XLEN-1:0]       r_wdata;

  logic w_empty, w_accept, w_kill, w_pop, w_bypass, w_push, w_push_live;
  logic [2**REG_ADDR_W-1:0] w_mask;

  assign w_empty   = (r_count == '0);
  assign loadReady = (r_count != FULL);
  assign w_accept  = loadValid && loadReady;
  assign w_kill    = aluValid && (aluRd != '0);
  assign w_pop     = !aluValid && !w_empty;

`ifdef WB_LOAD_BYPASS_EN
  assign w_bypass = !aluValid && w_empty && w_accept;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_accept && !w_bypass;
  // A load accepted alongside a same-rd ALU write is older than it, so it enters already dead.
  assign w_push_live = (loadRd != '0) && !(w_kill && (loadRd == aluRd));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_kill && (r_rd[i] == aluRd)) r_live[i] <= 1'b0;
      end
      if (w_pop) begin
        r_live[r_head] <= 1'b0;
        r_head         <= r_head + PTR_W'(1);
      end
      if (w_push) begin
        r_live[r_tail] <= w_push_live;
        r_tail         <= r_tail + PTR_W'(1);
      end
      r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_tail]   <= loadRd;
      r_data[r_tail] <= loadData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_des   <= '0;
      r_wdata <= '0;
    end else if (aluValid) begin
      r_we    <= (aluRd != '0);
      r_des   <= aluRd;
      r_wdata <= aluData;
    end else if (w_pop) begin
      r_we    <= r_live[r_head] && (r_rd[r_head] != '0);
      r_des   <= r_rd[r_head];
      r_wdata <= r_data[r_head];
    end else if (w_bypass) begin
      r_we    <= (loadRd != '0);
      r_des   <= loadRd;
      r_wdata <= loadData;
    end else begin
      r_we <= 1'b0;
    end
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i]) w_mask[r_rd[i]] = 1'b1;
    end
  end

  assign pendingMask = w_mask;
  assign fifoCount   = r_count;
  assign writeEnable = r_we;
  assign desRegister = r_des;
  assign writeData   = r_wdata;

endmodule

// File: doc/regfile_write_sequencer.md
Name: regfile_write_sequencer

Overview:
- Write-side front end of the register file: merges ALU results and load-unit results into the register file's single write port (writeEnable / desRegister / writeData).
- ALU results are never stalled. Load results use a valid/ready handshake and a small in-order FIFO.
- Exports a pending-write mask so decode can stall on registers with an outstanding load write.
- Sits between the execute/LSU stage and the register file.

Parameters:
- XLEN, 32, data width of every write.
- DEPTH, 4, load FIFO entries (power of 2, >= 2).
- REG_ADDR_W, 5, register index width.

Ports:
- clk  input  1  system clock, all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- aluValid  input  1  ALU result present this cycle
- aluRd  input  REG_ADDR_W  ALU destination register
- aluData  input  XLEN  ALU result
- loadValid  input  1  load result offered
- loadReady  output  1  sequencer can accept load (= FIFO not full)
- loadRd  input  REG_ADDR_W  load destination register
- loadData  input  XLEN  load result
- writeEnable  output  1  register-file write strobe (registered)
- desRegister  output  REG_ADDR_W  register-file write address (registered)
- writeData  output  XLEN  register-file write data (registered)
- pendingMask  output  2**REG_ADDR_W  bit r set when a live FIFO entry targets register r
- fifoCount  output  log2(DEPTH)+1  live + killed entries currently held

Behaviour:
- Reset (async, rst=1): writeEnable=0, desRegister=0, writeData=0, FIFO empty, fifoCount=0, pendingMask=0, all entry valid bits cleared. Takes effect immediately mid-operation; an in-flight load is lost and must be re-sent by the LSU.
- Load accept: a load is accepted on a posedge with loadValid && loadReady. loadReady = (fifoCount != DEPTH); it is combinational from state only, never from loadValid.
- Output register load, each posedge, in strict priority order:
  1. aluValid: ALU write issued. writeEnable=(aluRd!=0), desRegister=aluRd, writeData=aluData.
  2. else if FIFO non-empty: pop the head. writeEnable = head live && head rd!=0.
  3. else if a load is accepted this cycle: bypass it directly (see Optional Feature).
  4. else: writeEnable=0; desRegister and writeData hold their previous values.
- Enqueue rule: an accepted load is enqueued when not bypassed, i.e. when aluValid=1 or the FIFO is non-empty. Loads are written in acceptance order.
- Register 0: an rd=0 load is still accepted and enqueued but marked dead. It never sets pendingMask or writeEnable.
- Latency:
  - ALU: writeEnable in the cycle after the aluValid edge.
  - Load bypass: 1 cycle.
  - Queued load: >= 2 cycles.
  - The sequencer accepts one ALU result and one load per cycle.
- WAW kill: when aluValid and aluRd!=0, every live FIFO entry with rd==aluRd is marked dead in the same edge (the ALU result is younger).
  - This includes a load accepted in the same cycle with loadRd==aluRd: it enqueues dead.
  - Dead entries still pop in order, with writeEnable=0 for that cycle.
- Simultaneous pop and push: allowed in the same edge, fifoCount unchanged. When full (fifoCount=DEPTH), a pop in that cycle does not raise loadReady until the next cycle.
- Pointers: wrap modulo DEPTH. fifoCount distinguishes full from empty.
- pendingMask: combinational OR of one-hot(rd) over live entries, updated one edge after an enqueue, kill, or pop.

Optional Feature:
- Macro: WB_LOAD_BYPASS_EN.
- Defined: the bypass path in priority item 3 exists; load latency is 1 cycle when the FIFO is empty and aluValid=0.
- Undefined: every accepted load is enqueued. Priority item 3 is removed, so minimum load latency is 2 cycles. Ordering, kill, and handshake rules are unchanged.

Test Plan:
- Reset: assert rst mid-stream with 3 entries queued -> writeEnable=0, fifoCount=0, loadReady=1, pendingMask=0 immediately, before any clock edge.
- Bypass: idle, then load rd=5 data=0xDEADBEEF -> next cycle writeEnable=1, desRegister=5, writeData=0xDEADBEEF.
  - With WB_LOAD_BYPASS_EN undefined: the same write appears one cycle later.
- Contention: aluValid for 4 consecutive cycles with loads rd=1..4 offered each cycle (DEPTH=4) -> ALU writes appear first, loadReady=0 after 4 accepts, then loads 1..4 are written in order.
- WAW kill: queue a load rd=7 data=0x11, then ALU rd=7 data=0x22 -> pendingMask[7] clears. The register-file write sequence is rd7=0x22 then a dead pop with writeEnable=0, so rd7 ends at 0x22.
- Register 0: ALU rd=0 and load rd=0 -> both accepted, writeEnable never asserted, pendingMask[0] stays 0.
- Full boundary: FIFO full with a simultaneous pop and loadValid -> no accept that cycle; accepted next cycle; fifoCount sequence 4,3,4.
